l2_mem_responder: RTL and testbench

Memory-side responder for the L2 cache's two line-granular memory channels (instruction `memi_*`, data `memd_*`). Accepts one read or write request at a time, arbitrates between channels, models a fixed access latency, and returns a single-cycle `ready` pulse with 128-bit line data. Sits between the L2 cache and the testbench/system boundary as the shared main-memory model, backed by one line array so both channels see a coherent memory image.

---
 rtl/l2_mem_responder_if.sv | 47 ++++
 rtl/l2_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_l2_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_responder_if.sv
// Line-granular L2 <-> main memory channel bundle.
// Carries both the instruction and data channels.
interface l2_mem_responder_if;
    logic         memi_read;
    logic         memi_write;
    logic [27:0]  memi_addr;
    logic [127:0] memi_wdata;
    logic [127:0] memi_rdata;
    logic         memi_ready;

    logic         memd_read;
    logic         memd_write;
    logic [27:0]  memd_addr;
    logic [127:0] memd_wdata;
    logic [127:0] memd_rdata;
    logic         memd_ready;

    modport master (
        output memi_read,
        output memi_write,
        output memi_addr,
        output memi_wdata,
        input  memi_rdata,
        input  memi_ready,
        output memd_read,
        output memd_write,
        output memd_addr,
        output memd_wdata,
        input  memd_rdata,
        input  memd_ready
    );

    modport slave (
        input  memi_read,
        input  memi_write,
        input  memi_addr,
        input  memi_wdata,
        output memi_rdata,
        output memi_ready,
        input  memd_read,
        input  memd_write,
        input  memd_addr,
        input  memd_wdata,
        output memd_rdata,
        output memd_ready
    );
endinterface

// File: rtl/l2_mem_responder.sv
// Shared main-memory model behind the L2 I/D line channels.
// One transaction at a time, fixed latency, alternating tie-break.
module l2_mem_responder #(
    parameter int LATENCY = 8,
    parameter int IDX_W   = 8
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    l2_mem_responder_if.slave mem
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    localparam int       DEPTH    = 1 << IDX_W;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
    localparam bit       LAT1     = (LATENCY == 1);

    logic [127:0]     r_mem [DEPTH];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic             r_last_d;
    logic             w_last_d_nxt;

    logic [IDX_W-1:0] r_idx;
    logic [127:0]     r_wdata;
    logic             r_wr;

    logic             r_i_ready;
    logic             r_d_ready;
    logic [127:0]     r_i_rdata;
    logic [127:0]     r_d_rdata;

    logic             w_i_pend;
    logic             w_d_pend;
    logic             w_req_d;
    logic             w_req_wr;
    logic [27:0]      w_req_addr;
    logic [127:0]     w_req_wdata;
    logic             w_grant;
    logic             w_fire;

    logic             w_op_d;
    logic             w_op_wr;
    logic [IDX_W-1:0] w_op_idx;
    logic [127:0]     w_op_wdata;

    logic             w_unused_addr;

    assign w_i_pend = mem.memi_read | mem.memi_write;
    assign w_d_pend = mem.memd_read | mem.memd_write;

    // On a tie the channel not served last wins.
    assign w_req_d = w_d_pend & (~w_i_pend | ~r_last_d);

    // Write dominates a read raised on the same channel.
    assign w_req_wr    = w_req_d ? mem.memd_write : mem.memi_write;
    assign w_req_addr  = w_req_d ? mem.memd_addr  : mem.memi_addr;
    assign w_req_wdata = w_req_d ? mem.memd_wdata : mem.memi_wdata;

    // Upper address bits alias onto the same line on purpose.
    assign w_unused_addr = ^{mem.memi_addr[27:IDX_W],
                             mem.memd_addr[27:IDX_W]};

    // Operation that completes this cycle: live request when a
    // single-cycle build fires straight from IDLE, latched otherwise.
    always_comb begin
        w_op_d     = 1'b0;
        w_op_wr    = 1'b0;
        w_op_idx   = '0;
        w_op_wdata = '0;
        if (r_state == IDLE) begin
            w_op_d     = w_req_d;
            w_op_wr    = w_req_wr;
            w_op_idx   = w_req_addr[IDX_W-1:0];
            w_op_wdata = w_req_wdata;
        end else begin
            w_op_d     = (r_state == BUSY_D);
            w_op_wr    = r_wr;
            w_op_idx   = r_idx;
            w_op_wdata = r_wdata;
        end
    end

    // Next-state, grant and completion decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_d_nxt = r_last_d;
        w_grant      = 1'b0;
        w_fire       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_i_pend | w_d_pend) begin
                    w_grant      = 1'b1;
                    w_state_nxt  = w_req_d ? BUSY_D : BUSY_I;
                    w_cnt_nxt    = CNT_LOAD;
                    w_last_d_nxt = w_req_d;
                    w_fire       = LAT1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    w_fire    = (r_cnt == 8'd1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Control state and the latched copy of the granted request.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_last_d <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last_d <= w_last_d_nxt;
            if (w_grant) begin
                r_idx   <= w_req_addr[IDX_W-1:0];
                r_wdata <= w_req_wdata;
                r_wr    <= w_req_wr;
            end
        end
    end

    // Line array commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (proc_reset_n && w_fire && w_op_wr) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    // Completion pulse and read data, visible the cycle after fire.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ready <= w_fire & ~w_op_d;
            r_d_ready <= w_fire & w_op_d;
            if (w_fire && !w_op_wr && !w_op_d) begin
                r_i_rdata <= r_mem[w_op_idx];
            end
            if (w_fire && !w_op_wr && w_op_d) begin
                r_d_rdata <= r_mem[w_op_idx];
            end
        end
    end

    assign mem.memi_ready = r_i_ready;
    assign mem.memd_ready = r_d_ready;
    assign mem.memi_rdata = r_i_rdata;
    assign mem.memd_rdata = r_d_rdata;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: transaction-level memory model,
// expected completions queued at issue, checked by a monitor.
module tb_l2_mem_responder;

    localparam int L = 8;

    typedef struct {
        int           ch;
        longint       cyc;
        logic [127:0] data;
    } exp_t;

    logic   clk = 1'b0;
    logic   proc_reset_n = 1'b0;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    exp_t         sb[$];
    logic [127:0] model_mem [2][256];
    logic [127:0] last_rd [4];
    logic [127:0] hold_rd [4];
    bit           model_last_d [2];

    l2_mem_responder_if ifc0();
    l2_mem_responder_if ifc1();

    l2_mem_responder #(.LATENCY(L), .IDX_W(8)) u_dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem          (ifc0)
    );

    l2_mem_responder #(.LATENCY(1), .IDX_W(8)) u_dut1 (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem          (ifc1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int ch, bit ok,
                                logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s ch%0d cyc%0d: got %h want %h",
                     nm, ch, cyc, act, exp);
        end
    endfunction

    // Apply one operation to the model in grant order and queue
    // the completion the monitor must see on that channel.
    function automatic void push_exp(int dut, int chn, bit wr, int idx,
                                     logic [127:0] wd, longint at);
        int   c;
        exp_t e;
        c = dut * 2 + chn;
        if (wr) begin
            model_mem[dut][idx] = wd;
        end else begin
            last_rd[c] = model_mem[dut][idx];
        end
        e.ch   = c;
        e.cyc  = at;
        e.data = last_rd[c];
        sb.push_back(e);
    endfunction

    // Monitor: pop and compare whenever a channel reports ready.
    always @(negedge clk) begin
        logic         rdy [4];
        logic [127:0] rd [4];
        int           k;
        rdy[0] = ifc0.memi_ready; rd[0] = ifc0.memi_rdata;
        rdy[1] = ifc0.memd_ready; rd[1] = ifc0.memd_rdata;
        rdy[2] = ifc1.memi_ready; rd[2] = ifc1.memi_rdata;
        rdy[3] = ifc1.memd_ready; rd[3] = ifc1.memd_rdata;
        if (proc_reset_n) begin
            for (int c = 0; c < 4; c++) begin
                k = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (k < 0 && sb[j].ch == c) k = j;
                if (rdy[c]) begin
                    chk("ready_cycle", c, k >= 0 && sb[k].cyc == cyc,
                        128'(cyc), (k >= 0) ? 128'(sb[k].cyc) : '1);
                    if (k >= 0) begin
                        chk("rdata", c, rd[c] === sb[k].data,
                            rd[c], sb[k].data);
                        hold_rd[c] = sb[k].data;
                        sb.delete(k);
                    end
                end else begin
                    if (k >= 0 && sb[k].cyc < cyc) begin
                        chk("ready_missing", c, rdy[c] === 1'b1,
                            128'(cyc), 128'(sb[k].cyc));
                        hold_rd[c] = sb[k].data;
                        sb.delete(k);
                    end
                    chk("rdata_hold", c, rd[c] === hold_rd[c],
                        rd[c], hold_rd[c]);
                end
            end
            if (rdy[0] || rdy[1])
                chk("dual_ready", 0, !(rdy[0] && rdy[1]),
                    128'({rdy[0], rdy[1]}), 128'b0);
            if (rdy[2] || rdy[3])
                chk("dual_ready", 2, !(rdy[2] && rdy[3]),
                    128'({rdy[2], rdy[3]}), 128'b0);
        end
    end

    task automatic run_round(input bit ie, input bit iw,
                             input logic [27:0] ia, input logic [127:0] iwd,
                             input bit de, input bit dw,
                             input logic [27:0] da, input logic [127:0] dwd);
        longint t;
        bit     idn;
        bit     ddn;
        bit     ir;
        bit     dr;
        int     budget;
        t = cyc;
        if (ie && de) begin
            if (model_last_d[0]) begin
                push_exp(0, 0, iw, int'(ia[7:0]), iwd, t + L);
                push_exp(0, 1, dw, int'(da[7:0]), dwd, t + 2 * L + 1);
                model_last_d[0] = 1'b1;
            end else begin
                push_exp(0, 1, dw, int'(da[7:0]), dwd, t + L);
                push_exp(0, 0, iw, int'(ia[7:0]), iwd, t + 2 * L + 1);
                model_last_d[0] = 1'b0;
            end
        end else if (ie) begin
            push_exp(0, 0, iw, int'(ia[7:0]), iwd, t + L);
            model_last_d[0] = 1'b0;
        end else if (de) begin
            push_exp(0, 1, dw, int'(da[7:0]), dwd, t + L);
            model_last_d[0] = 1'b1;
        end
        ifc0.memi_write = ie & iw;
        ifc0.memi_read  = ie & (~iw | 1'($urandom_range(0, 1)));
        ifc0.memi_addr  = ia;
        ifc0.memi_wdata = iwd;
        ifc0.memd_write = de & dw;
        ifc0.memd_read  = de & (~dw | 1'($urandom_range(0, 1)));
        ifc0.memd_addr  = da;
        ifc0.memd_wdata = dwd;
        idn = !ie;
        ddn = !de;
        budget = 0;
        while (!(idn && ddn) && budget < 3 * L + 10) begin
            @(negedge clk);
            ir = ifc0.memi_ready;
            dr = ifc0.memd_ready;
            @(posedge clk);
            #1;
            if (ir && !idn) begin
                idn = 1'b1;
                ifc0.memi_read  = 1'b0;
                ifc0.memi_write = 1'b0;
            end
            if (dr && !ddn) begin
                ddn = 1'b1;
                ifc0.memd_read  = 1'b0;
                ifc0.memd_write = 1'b0;
            end
            budget++;
        end
        chk("round_done", 0, idn && ddn, 128'({idn, ddn}), 128'b11);
        ifc0.memi_read  = 1'b0;
        ifc0.memi_write = 1'b0;
        ifc0.memd_read  = 1'b0;
        ifc0.memd_write = 1'b0;
    endtask

    task automatic reset_model();
        for (int c = 0; c < 4; c++) begin
            last_rd[c] = '0;
            hold_rd[c] = '0;
        end
        model_last_d[0] = 1'b0;
        model_last_d[1] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_ready"}, 0, ifc0.memi_ready === 1'b0,
            128'(ifc0.memi_ready), 128'b0);
        chk({nm, "_ready"}, 1, ifc0.memd_ready === 1'b0,
            128'(ifc0.memd_ready), 128'b0);
        chk({nm, "_rdata"}, 0, ifc0.memi_rdata === '0,
            ifc0.memi_rdata, 128'b0);
        chk({nm, "_rdata"}, 1, ifc0.memd_rdata === '0,
            ifc0.memd_rdata, 128'b0);
    endtask

    logic [127:0] a5;
    logic [127:0] rnd;

    initial begin
        #2000000;
        $display("FAIL timeout ch0 cyc%0d: got hang want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        {ifc0.memi_read, ifc0.memi_write, ifc0.memd_read, ifc0.memd_write} = '0;
        {ifc1.memi_read, ifc1.memi_write, ifc1.memd_read, ifc1.memd_write} = '0;
        ifc0.memi_addr = '0; ifc0.memi_wdata = '0;
        ifc0.memd_addr = '0; ifc0.memd_wdata = '0;
        ifc1.memi_addr = '0; ifc1.memi_wdata = '0;
        ifc1.memd_addr = '0; ifc1.memd_wdata = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) model_mem[d][i] = '0;
        reset_model();
        a5 = {16{8'hA5}};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie after reset: D first, then I first on the repeat.
        run_round(1, 0, 28'h0000020, '0, 1, 0, 28'h0000030, '0);
        run_round(1, 0, 28'h0000021, '0, 1, 0, 28'h0000031, '0);

        // D write then read back.
        run_round(0, 0, '0, '0, 1, 1, 28'h0000010, a5);
        run_round(0, 0, '0, '0, 1, 0, 28'h0000010, '0);

        // Cross-channel read through an aliased address.
        run_round(0, 0, '0, '0, 1, 1, 28'h0000003, 128'h1234);
        run_round(1, 0, 28'h0000103, '0, 0, 0, '0, '0);

        // Writeback then allocate with no gap, then read the victim.
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_round(0, 0, '0, '0, 1, 1, 28'h0000040, rnd);
        run_round(0, 0, '0, '0, 1, 0, 28'h0000010, '0);
        run_round(0, 0, '0, '0, 1, 0, 28'h0000040, '0);

        // Reset in the fourth cycle of a D write abandons it.
        repeat (2) @(posedge clk);
        #1;
        ifc0.memd_write = 1'b1;
        ifc0.memd_addr  = 28'h0000010;
        ifc0.memd_wdata = {16{8'h5A}};
        repeat (3) @(posedge clk);
        #1;
        proc_reset_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        ifc0.memd_write = 1'b0;
        reset_model();
        @(posedge clk);
        #1;
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_round(0, 0, '0, '0, 1, 0, 28'h0000010, '0);

        // Single-cycle build: write, then a held read repeats every 2.
        rnd = {$urandom, $urandom, $urandom, $urandom};
        begin
            longint t;
            t = cyc;
            push_exp(1, 1, 1, 5, rnd, t + 1);
            ifc1.memd_write = 1'b1;
            ifc1.memd_addr  = 28'h0000005;
            ifc1.memd_wdata = rnd;
            repeat (2) @(posedge clk);
            #1;
            ifc1.memd_write = 1'b0;
            ifc1.memi_read  = 1'b1;
            ifc1.memi_addr  = 28'h1230005;
            for (int j = 0; j < 4; j++)
                push_exp(1, 0, 0, 5, '0, t + 3 + 2 * j);
            repeat (8) @(posedge clk);
            #1;
            ifc1.memi_read = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end

        // Random traffic on the main instance.
        for (int r = 0; r < 40; r++) begin
            bit           ie, iw, de, dw;
            logic [27:0]  ia, da;
            logic [127:0] iwd, dwd;
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            if (!ie && !de) de = 1'b1;
            iw = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = {20'($urandom), 8'($urandom_range(0, 7))};
            da = {20'($urandom), 8'($urandom_range(0, 7))};
            iwd = {$urandom, $urandom, $urandom, $urandom};
            dwd = {$urandom, $urandom, $urandom, $urandom};
            run_round(ie, iw, ia, iwd, de, dw, da, dwd);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 0, sb.size() == 0, 128'(sb.size()), 128'b0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
